// File: rtl/mtimer.sv
// 64-bit machine timer with a prescaler and a lockable compare register.
// Raises a level interrupt on int_flag_o[0] while mtime >= mtimecmp; reads and writes are acked one cycle later.
module mtimer #(
  parameter int PRESC_W = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic        ack_o,
  output logic [7:0]  int_flag_o
);

  logic               en, ie;
  logic [PRESC_W-1:0] presc, pre_cnt;
  logic [63:0]        mtime, mtimecmp;
  logic [31:0]        hi_shadow;
  logic               ovf, lock, pend;

  logic        wr, rd, tick, mtime_wr, wrap;
  logic [2:0]  idx;
  logic [31:0] rd_val, ctrl_rd;
  logic        unused_addr;

  assign idx         = addr_i[4:2];
  assign wr          = req_i & we_i;
  assign rd          = req_i & ~we_i;
  assign tick        = en && (pre_cnt == presc);
  assign mtime_wr    = wr && ((idx == 3'd2) || (idx == 3'd3));
  // A bus write to either mtime half blocks that cycle's increment, and so any wrap.
  assign wrap        = tick && !mtime_wr && (&mtime);
  assign unused_addr = ^{addr_i[31:5], addr_i[1:0]};

  always_comb begin
    ctrl_rd              = '0;
    ctrl_rd[0]           = en;
    ctrl_rd[1]           = ie;
    ctrl_rd[8 +: PRESC_W] = presc;
  end

  always_comb begin
    rd_val = '0;
    case (idx)
      3'd0:    rd_val = ctrl_rd;
      3'd1:    rd_val = {29'd0, lock, ovf, pend};
      3'd2:    rd_val = mtime[31:0];
      3'd3:    rd_val = hi_shadow;
      3'd4:    rd_val = mtimecmp[31:0];
      3'd5:    rd_val = mtimecmp[63:32];
      default: rd_val = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_o    <= '0;
      ack_o     <= 1'b0;
      en        <= 1'b0;
      ie        <= 1'b0;
      presc     <= '0;
      pre_cnt   <= '0;
      mtime     <= '0;
      mtimecmp  <= '1;
      hi_shadow <= '0;
      ovf       <= 1'b0;
      lock      <= 1'b0;
      pend      <= 1'b0;
    end else begin
      ack_o  <= req_i;
      data_o <= rd ? rd_val : 32'd0;
      pend   <= (mtime >= mtimecmp);

      if (wr && (idx == 3'd0)) begin
        en      <= data_i[0];
        ie      <= data_i[1];
        presc   <= data_i[8 +: PRESC_W];
        pre_cnt <= '0;
      end else if (en) begin
        pre_cnt <= tick ? '0 : pre_cnt + 1'b1;
      end

      if (wr && (idx == 3'd2))      mtime[31:0]  <= data_i;
      else if (wr && (idx == 3'd3)) mtime[63:32] <= data_i;
      else if (tick)                mtime        <= mtime + 64'd1;

      // Set has priority over a same-cycle write-1-to-clear.
      if (wrap)                                         ovf <= 1'b1;
      else if (wr && (idx == 3'd1) && data_i[1])        ovf <= 1'b0;

      if (rd && (idx == 3'd2)) hi_shadow <= mtime[63:32];

      if (wr && (idx == 3'd4)) begin
        mtimecmp[31:0] <= data_i;
        lock           <= 1'b1;
      end else if (wr && (idx == 3'd5)) begin
        mtimecmp[63:32] <= data_i;
        lock            <= 1'b0;
      end
    end
  end

  assign int_flag_o = {7'd0, pend & ie & ~lock};

endmodule

// File: tb/tb_mtimer.sv
// Scoreboarded bench for mtimer: directed scenarios plus randomized bus traffic against a cycle model.
module tb_mtimer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] data_o;
  logic        ack_o;
  logic [7:0]  int_flag_o;

  always #5 clk = ~clk;

  mtimer #(.PRESC_W(8)) dut (
    .clk(clk), .rst(rst), .req_i(req), .we_i(we), .addr_i(addr),
    .data_i(wdata), .data_o(data_o), .ack_o(ack_o), .int_flag_o(int_flag_o)
  );

  int tests = 0;
  int fails = 0;

  // Reference state: whole 64-bit quantities, updated once per clock edge.
  logic [31:0]     exp_q[$];
  bit              m_en, m_ie, m_ovf, m_lock, m_pend;
  int unsigned     m_presc, m_pre;
  longint unsigned m_time, m_cmp;
  logic [31:0]     m_shadow;
  logic [7:0]      exp_int = '0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_en = 0; m_ie = 0; m_ovf = 0; m_lock = 0; m_pend = 0;
    m_presc = 0; m_pre = 0; m_time = 0; m_cmp = 64'hFFFF_FFFF_FFFF_FFFF;
    m_shadow = '0; exp_int = '0;
  endfunction

  function automatic void model_step(input bit r, input bit q, input bit w,
                                     input logic [31:0] a, input logic [31:0] d);
    int unsigned     idx;
    bit              tick, mwr, wrapped;
    logic [31:0]     rv;
    longint unsigned t0;
    if (r) begin
      model_reset();
      return;
    end
    idx  = a[4:2];
    tick = m_en && (m_pre == m_presc);
    t0   = m_time;
    case (idx)
      0:       rv = (m_presc << 8) | (32'(m_ie) << 1) | 32'(m_en);
      1:       rv = {29'd0, m_lock, m_ovf, m_pend};
      2:       rv = t0[31:0];
      3:       rv = m_shadow;
      4:       rv = m_cmp[31:0];
      5:       rv = m_cmp[63:32];
      default: rv = 32'd0;
    endcase
    if (q) exp_q.push_back(w ? 32'd0 : rv);

    m_pend  = (t0 >= m_cmp);
    mwr     = q && w && (idx == 2 || idx == 3);
    wrapped = 0;
    if (q && !w && idx == 2) m_shadow = t0[63:32];
    if (mwr) begin
      if (idx == 2) m_time = {t0[63:32], d};
      else          m_time = {d, t0[31:0]};
    end else if (tick) begin
      wrapped = (t0 == 64'hFFFF_FFFF_FFFF_FFFF);
      m_time  = t0 + 1;
    end
    if (wrapped) m_ovf = 1;
    else if (q && w && idx == 1 && d[1]) m_ovf = 0;

    if (q && w && idx == 0) begin
      m_en = d[0]; m_ie = d[1]; m_presc = d[15:8]; m_pre = 0;
    end else if (m_en) begin
      m_pre = tick ? 0 : m_pre + 1;
    end

    if (q && w && idx == 4) begin m_cmp[31:0]  = d; m_lock = 1; end
    if (q && w && idx == 5) begin m_cmp[63:32] = d; m_lock = 0; end
    exp_int = {7'd0, m_pend & m_ie & !m_lock};
  endfunction

  // Drive one cycle on the falling edge; the model advances to the state after the next rising edge.
  task automatic cyc(input bit r, input bit q, input bit w, input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    rst = r; req = q; we = w; addr = a; wdata = d;
    model_step(r, q, w, a, d);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    cyc(0, 1, 1, a, d);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 32'd0, 32'd0);
  endtask

  task automatic rd_chk(input string name, input logic [31:0] a,
                        input logic [31:0] exp, input logic [31:0] mask);
    cyc(0, 1, 0, a, 32'd0);
    idle(1);
    chk(name, data_o & mask, exp);
  endtask

  // Monitor: compares every acked response against the scoreboard queue.
  always @(posedge clk) begin
    #1;
    chk("int_flag", {24'd0, int_flag_o}, {24'd0, exp_int});
    if (ack_o) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL ack_without_request: got ack=1 expected ack=0 at %0t", $time);
      end else begin
        chk("rd_data", data_o, exp_q.pop_front());
      end
    end else begin
      chk("idle_data", data_o, 32'd0);
    end
  end

  initial begin
    model_reset();
    cyc(1, 0, 0, 32'd0, 32'd0);
    cyc(1, 0, 0, 32'd0, 32'd0);
    rd_chk("rst_cmp_lo", 32'h10, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    rd_chk("rst_ctrl", 32'h0, 32'h0, 32'hFFFF_FFFF);

    // Interrupt fires one cycle after mtime reaches 10.
    wr(32'h10, 32'd10);
    wr(32'h14, 32'd0);
    wr(32'h0, 32'h3);
    idle(11);
    chk("int_before_cmp", {24'd0, int_flag_o}, 32'h0);
    idle(1);
    chk("int_at_cmp", {24'd0, int_flag_o}, 32'h1);

    // Half-written compare suppresses the interrupt until the high half lands.
    wr(32'h10, 32'd5);
    idle(1);
    chk("int_locked", {24'd0, int_flag_o}, 32'h0);
    rd_chk("lock_set", 32'h4, 32'h4, 32'h4);
    wr(32'h14, 32'd0);
    idle(1);
    chk("int_unlocked", {24'd0, int_flag_o}, 32'h1);
    rd_chk("lock_clr", 32'h4, 32'h0, 32'h4);

    // Prescaler 3: one tick per 4 cycles; a CTRL write restarts the period.
    wr(32'h0, 32'h0);
    wr(32'h8, 32'h0);
    wr(32'hC, 32'h0);
    wr(32'h0, 32'h301);
    idle(3);
    cyc(0, 1, 0, 32'h8, 32'd0);
    cyc(0, 1, 0, 32'h8, 32'd0);
    chk("presc_pre_tick", data_o, 32'd0);
    idle(1);
    chk("presc_post_tick", data_o, 32'd1);
    wr(32'h0, 32'h301);
    idle(3);
    cyc(0, 1, 0, 32'h8, 32'd0);
    cyc(0, 1, 0, 32'h8, 32'd0);
    chk("presc_restart_hold", data_o, 32'd1);
    idle(1);
    chk("presc_restart_tick", data_o, 32'd2);

    // 64-bit wrap sets OVF; clear works; clear coincident with wrap loses.
    wr(32'h0, 32'h1);
    wr(32'hC, 32'hFFFF_FFFF);
    wr(32'h8, 32'hFFFF_FFFE);
    idle(2);
    rd_chk("ovf_set", 32'h4, 32'h2, 32'h2);
    wr(32'h4, 32'h2);
    rd_chk("ovf_clr", 32'h4, 32'h0, 32'h2);
    wr(32'hC, 32'hFFFF_FFFF);
    wr(32'h8, 32'hFFFF_FFFF);
    wr(32'h4, 32'h2);
    rd_chk("ovf_set_wins", 32'h4, 32'h2, 32'h2);

    // Atomic read: HI comes from the shadow captured by the LO read.
    wr(32'hC, 32'h1);
    wr(32'h8, 32'hFFFF_FFFF);
    rd_chk("shadow_lo", 32'h8, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    rd_chk("shadow_hi", 32'hF, 32'h1, 32'hFFFF_FFFF);

    // Bus write beats a same-cycle tick.
    wr(32'h9, 32'h100);
    rd_chk("write_beats_tick", 32'h8, 32'h100, 32'hFFFF_FFFF);

    // Reset while interrupt is pending.
    wr(32'h10, 32'd0);
    wr(32'h14, 32'd0);
    wr(32'h0, 32'h3);
    idle(2);
    chk("int_pre_reset", {24'd0, int_flag_o}, 32'h1);
    cyc(1, 1, 1, 32'h10, 32'd7);
    idle(1);
    chk("int_after_reset", {24'd0, int_flag_o}, 32'h0);
    rd_chk("cmp_hi_after_reset", 32'h14, 32'hFFFF_FFFF, 32'hFFFF_FFFF);

    // Randomized traffic checked by the monitor against the model.
    for (int n = 0; n < 3000; n++) begin
      int unsigned r, idx;
      logic [31:0] a, d;
      r   = $urandom_range(0, 199);
      idx = $urandom_range(0, 7);
      a   = ($urandom & 32'hFFFF_FFE0) | (idx << 2) | $urandom_range(0, 3);
      case (idx)
        0:       d = ($urandom_range(0, 3) << 8) | ($urandom_range(0, 1) << 1) | 32'(($urandom_range(0, 4) != 0));
        2:       d = ($urandom_range(0, 5) == 0) ? 32'hFFFF_FFF0 : $urandom_range(0, 300);
        3:       d = ($urandom_range(0, 5) == 0) ? 32'hFFFF_FFFF : 32'd0;
        4:       d = $urandom_range(0, 400);
        5:       d = ($urandom_range(0, 7) == 0) ? 32'd1 : 32'd0;
        default: d = $urandom;
      endcase
      if (r < 2)        cyc(1, $urandom_range(0, 1), 1, a, d);
      else if (r < 90)  cyc(0, 1, $urandom_range(0, 1), a, d);
      else              idle(1);
    end
    idle(5);
    chk("queue_drain", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
